router_reg: RTL

Datapath register stage of the 1x3 packet router, directly downstream of the router control FSM. It consumes the FSM's one-hot state strobes and the source byte stream. It latches the header byte, buffers one payload byte across FIFO-full stalls, and drives the byte presented to the destination FIFOs. It also accumulates and checks packet parity, and returns `parity_done` / `low_pkt_valid` to the FSM.

---
 rtl/router_pkg.sv | 23 ++
 rtl/router_reg_if.sv | 38 +++
 rtl/router_parity.sv | 76 +++++++
 rtl/router_reg.sv | 100 ++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// router_pkg: constants and types shared by the router control FSM and datapath.
//   DATA_W       - byte width of the packet stream
//   ADDR_W       - width of the destination address field in the header byte
//   ADDR_INVALID - address code with no destination FIFO; such headers are dropped
//   router_state_e - control FSM state encoding, kept here so FSM and datapath agree
package router_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 2;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    StDecodeAddress,
    StLoadFirstData,
    StLoadData,
    StLoadParity,
    StFifoFullState,
    StLoadAfterFull,
    StWaitTillEmpty,
    StCheckParityError
  } router_state_e;

endpackage

// File: rtl/router_reg_if.sv
// router_reg_if: bundles the source byte stream, the control FSM state strobes and the
// datapath results of router_reg.
//   slave  - the register stage: consumes stream and strobes, drives results
//   master - the environment (source, FSM, destination FIFOs)
//   Stream:  pkt_valid, data_in, fifo_full
//   Strobes: detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg
//   Results: parity_done, low_pkt_valid, err, dout, internal_parity (running parity)
interface router_reg_if;
  import router_pkg::*;

  logic              pkt_valid;
  logic [DATA_W-1:0] data_in;
  logic              fifo_full;
  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              rst_int_reg;
  logic              parity_done;
  logic              low_pkt_valid;
  logic              err;
  logic [DATA_W-1:0] dout;
  logic [DATA_W-1:0] internal_parity;

  modport slave (
    input  pkt_valid, data_in, fifo_full,
    input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    output parity_done, low_pkt_valid, err, dout, internal_parity
  );

  modport master (
    output pkt_valid, data_in, fifo_full,
    output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    input  parity_done, low_pkt_valid, err, dout, internal_parity
  );

endinterface

// File: rtl/router_parity.sv
// router_parity: accumulates the XOR of header and payload bytes, captures the
// trailing parity byte and flags a mismatch once the packet body is complete.
//   clock, resetn   - system clock, synchronous active-low reset
//   detect_add      - start of a new packet, clears all parity state
//   lfd_state       - header is being forwarded; fold header into parity
//   ld_state        - payload / parity byte on data_in
//   full_state      - FIFO-full stall state; no accumulation
//   pkt_valid       - low marks data_in as the parity byte
//   parity_done     - packet body complete, compare is meaningful
//   header, data_in - latched header byte and current stream byte
//   internal_parity - running XOR of the packet
//   err             - parity mismatch, held until the next detect_add
module router_parity
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              full_state,
  input  logic              pkt_valid,
  input  logic              parity_done,
  input  logic [DATA_W-1:0] header,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] internal_parity,
  output logic              err
);

  logic [DATA_W-1:0] internal_parity_d, internal_parity_q;
  logic [DATA_W-1:0] packet_parity_d, packet_parity_q;
  logic              err_d, err_q;

  always_comb begin
    internal_parity_d = internal_parity_q;
    packet_parity_d   = packet_parity_q;
    err_d             = err_q;

    if (detect_add) begin
      internal_parity_d = '0;
    end else if (lfd_state) begin
      internal_parity_d = internal_parity_q ^ header;
    end else if (ld_state && pkt_valid && !full_state) begin
      // A byte diverted to the hold register on a full FIFO is counted here, once.
      internal_parity_d = internal_parity_q ^ data_in;
    end

    if (detect_add) begin
      packet_parity_d = '0;
    end else if (ld_state && !pkt_valid) begin
      packet_parity_d = data_in;
    end

    if (detect_add) begin
      err_d = 1'b0;
    end else if (parity_done) begin
      err_d = (internal_parity_q != packet_parity_q);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      internal_parity_q <= '0;
      packet_parity_q   <= '0;
      err_q             <= 1'b0;
    end else begin
      internal_parity_q <= internal_parity_d;
      packet_parity_q   <= packet_parity_d;
      err_q             <= err_d;
    end
  end

  assign internal_parity = internal_parity_q;
  assign err             = err_q;

endmodule

// File: rtl/router_reg.sv
// router_reg: datapath register stage of the 1x3 packet router. Latches the header,
// buffers one payload byte across FIFO-full stalls, drives the byte written to the
// destination FIFOs and reports parity status back to the control FSM.
//   clock  - system clock, all state on the rising edge
//   resetn - synchronous active-low reset
//   bus    - router_reg_if.slave: stream, FSM strobes in; dout and status flags out
module router_reg
  import router_pkg::*;
(
  input logic         clock,
  input logic         resetn,
  router_reg_if.slave bus
);

  logic [DATA_W-1:0] header_d, header_q;
  logic [DATA_W-1:0] hold_d, hold_q;
  logic [DATA_W-1:0] dout_d, dout_q;
  logic              parity_done_d, parity_done_q;
  logic              low_pkt_valid_d, low_pkt_valid_q;
  logic              err;
  logic [DATA_W-1:0] internal_parity;

  always_comb begin
    header_d        = header_q;
    hold_d          = hold_q;
    dout_d          = dout_q;
    parity_done_d   = parity_done_q;
    low_pkt_valid_d = low_pkt_valid_q;

    // Headers for the unused address are dropped; the previous header stays.
    if (bus.detect_add && bus.pkt_valid && (bus.data_in[ADDR_W-1:0] != ADDR_INVALID)) begin
      header_d = bus.data_in;
    end

    if (bus.lfd_state) begin
      dout_d = header_q;
    end else if (bus.ld_state && !bus.fifo_full) begin
      dout_d = bus.data_in;
    end else if (bus.laf_state) begin
      dout_d = hold_q;
    end

    // Park the byte that arrives while the destination FIFO is full.
    if (bus.ld_state && bus.fifo_full) begin
      hold_d = bus.data_in;
    end

    if (bus.rst_int_reg) begin
      low_pkt_valid_d = 1'b0;
    end else if (bus.ld_state && !bus.pkt_valid) begin
      low_pkt_valid_d = 1'b1;
    end

    // Second set term covers a parity byte that was parked during a stall.
    if (bus.detect_add) begin
      parity_done_d = 1'b0;
    end else if ((bus.ld_state && !bus.fifo_full && !bus.pkt_valid) ||
                 (bus.laf_state && low_pkt_valid_q && !parity_done_q)) begin
      parity_done_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      header_q        <= '0;
      hold_q          <= '0;
      dout_q          <= '0;
      parity_done_q   <= 1'b0;
      low_pkt_valid_q <= 1'b0;
    end else begin
      header_q        <= header_d;
      hold_q          <= hold_d;
      dout_q          <= dout_d;
      parity_done_q   <= parity_done_d;
      low_pkt_valid_q <= low_pkt_valid_d;
    end
  end

  router_parity u_parity (
    .clock           (clock),
    .resetn          (resetn),
    .detect_add      (bus.detect_add),
    .lfd_state       (bus.lfd_state),
    .ld_state        (bus.ld_state),
    .full_state      (bus.full_state),
    .pkt_valid       (bus.pkt_valid),
    .parity_done     (parity_done_q),
    .header          (header_q),
    .data_in         (bus.data_in),
    .internal_parity (internal_parity),
    .err             (err)
  );

  assign bus.dout            = dout_q;
  assign bus.parity_done     = parity_done_q;
  assign bus.low_pkt_valid   = low_pkt_valid_q;
  assign bus.err             = err;
  assign bus.internal_parity = internal_parity;

endmodule
